writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 41 ++++
 rtl/writeback_stage.sv | 64 ++++++
 tb/tb_writeback_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants, execute-result field layout and state type for the writeback stage
package wb_pkg;
  localparam int XLEN = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int DEST_W = 5;
  localparam int EX_DATA_LSB = 0;
  localparam int EX_PC_LSB = XLEN;
  localparam int EX_DEST_LSB = 2 * XLEN;
  localparam int EX_BR = EX_DEST_LSB + DEST_W;
  localparam int EX_WE = EX_BR + 1;
  localparam int EX_WB_W = EX_WE + 1;
  typedef enum logic {RUN, FLUSH} wb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular input buffer with push, pop and whole-buffer flush
module wb_fifo #(
  parameter int W = 71,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  // Pointer and occupancy update; reset and flush both empty the buffer
  always_ff @(posedge clock)
    if (reset || flush) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: buffers execute results, retires one per cycle into the register file, redirects fetch on taken branches
module writeback_stage #(
  parameter int XLEN = wb_pkg::XLEN,
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [wb_pkg::EX_WB_W-1:0] ex_wb,
  input  logic                       ex_wb_valid,
  output logic                       ex_wb_ready,
  input  logic [4:0]                 rd_addr_a,
  input  logic [4:0]                 rd_addr_b,
  output logic [XLEN-1:0]            rd_data_a,
  output logic [XLEN-1:0]            rd_data_b,
  output logic                       redirect_valid,
  output logic [XLEN-1:0]            redirect_pc,
  output logic [XLEN-1:0]            retired_count
);
  import wb_pkg::*;
  wb_state_e state;
  logic [EX_WB_W-1:0] head;
  logic full, empty, push, retire, wr_en, br;
  logic [XLEN-1:0] wdata, tgt;
  logic [DEST_W-1:0] dest;
  logic [XLEN-1:0] rf [32];
  assign wdata = head[EX_DATA_LSB +: XLEN];
  assign tgt = head[EX_PC_LSB +: XLEN];
  assign dest = head[EX_DEST_LSB +: DEST_W];
  assign br = head[EX_BR];
  assign retire = state == RUN && !empty;
  assign wr_en = retire && head[EX_WE] && dest != '0;
  assign ex_wb_ready = !reset && state == RUN && !full;
  assign push = ex_wb_valid && ex_wb_ready;
  assign rd_data_a = rd_addr_a == '0 ? '0 : (wr_en && dest == rd_addr_a) ? wdata : rf[rd_addr_a];
  assign rd_data_b = rd_addr_b == '0 ? '0 : (wr_en && dest == rd_addr_b) ? wdata : rf[rd_addr_b];
  wb_fifo #(.W(EX_WB_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(retire),
    .flush(state == FLUSH),
    .din(ex_wb),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // Register file write from the retiring head entry
  always_ff @(posedge clock)
    if (reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wr_en) rf[dest] <= wdata;
  // FSM, redirect pulse and retire counter; a retiring branch sends the stage into one FLUSH cycle
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      retired_count <= '0;
    end else begin
      state <= (retire && br) ? FLUSH : RUN;
      redirect_valid <= retire && br;
      if (retire && br) redirect_pc <= tgt;
      if (retire) retired_count <= retired_count + 1'b1;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with hand-computed expectations for writeback_stage
module tb_writeback_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [70:0] ex_wb = '0;
  logic ex_wb_valid = 1'b0;
  logic ex_wb_ready;
  logic [4:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [31:0] rd_data_a, rd_data_b, redirect_pc, retired_count;
  logic redirect_valid;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  writeback_stage dut (
    .clock(clock),
    .reset(reset),
    .ex_wb(ex_wb),
    .ex_wb_valid(ex_wb_valid),
    .ex_wb_ready(ex_wb_ready),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .retired_count(retired_count)
  );
  function automatic logic [70:0] mk(input logic we, input logic br, input logic [4:0] dest,
                                     input logic [31:0] pc, input logic [31:0] data);
    return {we, br, dest, pc, data};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    ex_wb_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask
  initial begin
    tick();
    check("rst_ready", 32'(ex_wb_ready), 0);
    check("rst_redir", 32'(redirect_valid), 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_count", retired_count, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(ex_wb_ready), 1);
    // single write to r3
    ex_wb = mk(1, 0, 5'd3, 32'h0, 32'h1234);
    ex_wb_valid = 1'b1;
    rd_addr_a = 5'd3;
    tick();
    ex_wb_valid = 1'b0;
    #1;
    check("bypass_r3", rd_data_a, 32'h1234);
    check("count_before_retire", retired_count, 0);
    tick();
    check("rf_r3", rd_data_a, 32'h1234);
    check("count_r3", retired_count, 1);
    // write to r0 is dropped
    do_reset();
    ex_wb = mk(1, 0, 5'd0, 32'h0, 32'hFFFF);
    ex_wb_valid = 1'b1;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    tick();
    ex_wb_valid = 1'b0;
    #1;
    check("r0_bypass", rd_data_b, 0);
    tick();
    check("r0_read", rd_data_a, 0);
    check("count_r0", retired_count, 1);
    // back-to-back pushes, push and pop together at occupancy 1
    do_reset();
    ex_wb = mk(1, 0, 5'd1, 32'h0, 32'hA);
    ex_wb_valid = 1'b1;
    #1;
    check("b2b_ready0", 32'(ex_wb_ready), 1);
    tick();
    ex_wb = mk(1, 0, 5'd2, 32'h0, 32'hB);
    rd_addr_a = 5'd1;
    #1;
    check("b2b_ready1", 32'(ex_wb_ready), 1);
    check("b2b_bypass1", rd_data_a, 32'hA);
    tick();
    check("b2b_count1", retired_count, 1);
    ex_wb = mk(1, 0, 5'd3, 32'h0, 32'hC);
    rd_addr_a = 5'd2;
    #1;
    check("b2b_ready2", 32'(ex_wb_ready), 1);
    check("b2b_bypass2", rd_data_a, 32'hB);
    tick();
    check("b2b_count2", retired_count, 2);
    ex_wb_valid = 1'b0;
    rd_addr_a = 5'd3;
    #1;
    check("b2b_ready3", 32'(ex_wb_ready), 1);
    check("b2b_bypass3", rd_data_a, 32'hC);
    tick();
    check("b2b_count3", retired_count, 3);
    rd_addr_a = 5'd1;
    rd_addr_b = 5'd2;
    #1;
    check("b2b_rf1", rd_data_a, 32'hA);
    check("b2b_rf2", rd_data_b, 32'hB);
    rd_addr_a = 5'd3;
    #1;
    check("b2b_rf3", rd_data_a, 32'hC);
    // taken branch flushes the younger entry
    do_reset();
    ex_wb = mk(1, 1, 5'd7, 32'h40, 32'h77);
    ex_wb_valid = 1'b1;
    tick();
    ex_wb = mk(1, 0, 5'd5, 32'h0, 32'h55);
    #1;
    check("br_ready_retire_cycle", 32'(ex_wb_ready), 1);
    check("br_no_redir_yet", 32'(redirect_valid), 0);
    tick();
    ex_wb_valid = 1'b0;
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd5;
    #1;
    check("br_redir", 32'(redirect_valid), 1);
    check("br_pc", redirect_pc, 32'h40);
    check("br_flush_ready", 32'(ex_wb_ready), 0);
    check("br_rf7", rd_data_a, 32'h77);
    check("br_count", retired_count, 1);
    check("br_flush_no_bypass", rd_data_b, 0);
    tick();
    check("br_pulse_end", 32'(redirect_valid), 0);
    check("br_ready_back", 32'(ex_wb_ready), 1);
    tick();
    check("br_rf5", rd_data_b, 0);
    check("br_count_after", retired_count, 1);
    // reset with buffered entries
    do_reset();
    ex_wb = mk(1, 1, 5'd4, 32'h80, 32'h44);
    ex_wb_valid = 1'b1;
    tick();
    ex_wb = mk(1, 0, 5'd6, 32'h0, 32'h66);
    reset = 1'b1;
    tick();
    ex_wb_valid = 1'b0;
    reset = 1'b0;
    rd_addr_a = 5'd4;
    rd_addr_b = 5'd6;
    #1;
    check("rstmid_rf4", rd_data_a, 0);
    check("rstmid_count", retired_count, 0);
    check("rstmid_redir", 32'(redirect_valid), 0);
    tick();
    check("rstmid_rf6", rd_data_b, 0);
    check("rstmid_count2", retired_count, 0);
    check("rstmid_redir2", 32'(redirect_valid), 0);
    // retired_count wrap
    do_reset();
    ex_wb = mk(1, 0, 5'd9, 32'h0, 32'h99);
    ex_wb_valid = 1'b1;
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    tick();
    ex_wb_valid = 1'b0;
    #1;
    check("wrap_preload", retired_count, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", retired_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
